// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with framing/parity checks, terminator detect and FWFT character FIFO
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int TERM_CH    = 'h10,
  parameter int BC_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [BC_W-1:0]                   bc,
  input  logic                              rx,
  output logic                              ch_vld,
  output logic [DATA_BITS-1:0]              ch,
  input  logic                              ch_rdy,
  output logic                              term,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              ovf,
  output logic [$clog2(FIFO_DEPTH):0]       level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  logic                 r_rx_meta, r_rxs;
  state_t               r_state, w_state_nxt;
  logic [BC_W-1:0]      r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err, r_frm_err;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp, w_rp_nxt;
  logic [LW-1:0]        r_level, w_level_nxt;
  logic                 r_ch_vld, r_term, r_frame_err, r_parity_err, r_ovf;
  logic [DATA_BITS-1:0] r_ch;
  logic                 w_sample, w_end, w_frm, w_is_term, w_good, w_push, w_pop, w_full, w_wr, w_par_bad;
  assign w_sample    = (r_state != IDLE) && (r_cnt == '0);
  assign w_end       = w_sample && (r_state == STOP) && (r_idx == 4'(STOP_BITS - 1));
  assign w_frm       = r_frm_err | ~r_rxs;
  assign w_is_term   = 32'(r_shift) == 32'(TERM_CH);
  assign w_good      = w_end && !w_frm && !r_par_err;
  assign w_push      = w_good && !w_is_term;
  assign w_par_bad   = (^r_shift) ^ r_rxs ^ (PARITY == 1);
  assign w_pop       = r_ch_vld && ch_rdy;
  assign w_full      = r_level == LW'(FIFO_DEPTH);
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_rp_nxt    = r_rp + AW'(w_pop);
  assign w_level_nxt = r_level + LW'(w_wr) - LW'(w_pop);
  assign ch_vld      = r_ch_vld;
  assign ch          = r_ch;
  assign term        = r_term;
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign ovf         = r_ovf;
  assign level       = r_level;
  // two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_rx_meta, r_rxs} <= 2'b11;
    else {r_rx_meta, r_rxs} <= {rx, r_rx_meta};
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // next-state: bit sequencing driven by mid-bit samples
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = r_rxs ? IDLE : START;
      START:   if (w_sample) w_state_nxt = r_rxs ? IDLE : DATA;
      DATA:    if (w_sample && r_idx == 4'(DATA_BITS - 1)) w_state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:     if (w_sample) w_state_nxt = STOP;
      STOP:    if (w_sample && r_idx == 4'(STOP_BITS - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // bit-period counter: half period from the start edge, then full periods
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (r_state == IDLE) r_cnt <= r_rxs ? r_cnt : bc >> 1;
    else r_cnt <= w_sample ? bc : r_cnt - 1'b1;
  // bit index, data shift register and per-frame error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_idx <= !w_sample ? r_idx : (w_state_nxt != r_state) ? 4'd0 : r_idx + 4'd1;
      if (w_sample && r_state == DATA) r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
      if (r_state == IDLE) begin
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
      end
      if (w_sample && r_state == PAR) r_par_err <= w_par_bad;
      if (w_sample && r_state == STOP && !r_rxs) r_frm_err <= 1'b1;
    end
  // frame-end status pulses; framing beats parity beats terminator
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_term       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_term       <= w_good && w_is_term;
      r_frame_err  <= w_end && w_frm;
      r_parity_err <= w_end && !w_frm && r_par_err;
    end
  // character storage, no reset needed since level gates visibility
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= r_shift;
  // FIFO pointers, occupancy, registered head with write bypass when empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_level  <= '0;
      r_ch_vld <= 1'b0;
      r_ch     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wp     <= r_wp + AW'(w_wr);
      r_rp     <= w_rp_nxt;
      r_level  <= w_level_nxt;
      r_ch_vld <= w_level_nxt != '0;
      r_ch     <= (w_wr && r_wp == w_rp_nxt) ? r_shift : r_mem[w_rp_nxt];
      r_ovf    <= r_ovf | (w_push && !w_wr);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven frames with a scoreboard on the FIFO drain
module tb_uart_rx_fifo;
  logic clk = 1'b0, rst_n = 1'b1, rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
  logic [15:0] bc = 16'd9;
  logic vld0, vld1, term0, term1, fe0, fe1, pe0, pe1, ovf0, ovf1;
  logic [7:0] ch0, ch1;
  logic [2:0] lvl0;
  logic [4:0] lvl1;
  int checks = 0, errors = 0;
  int n_term[2], n_fe[2], n_pe[2], et[2], ef[2], ep[2];
  int q0[$], q1[$];
  typedef struct {int d; bit [7:0] v; bit pb; bit sb; int gap; bit push; bit trm; bit fe; bit pe;} vec_t;
  vec_t tv[13];

  uart_rx_fifo #(.FIFO_DEPTH(4)) u0 (.clk(clk), .rst_n(rst_n), .bc(bc), .rx(rx0), .ch_vld(vld0), .ch(ch0),
    .ch_rdy(rdy0), .term(term0), .frame_err(fe0), .parity_err(pe0), .ovf(ovf0), .level(lvl0));
  uart_rx_fifo #(.PARITY(2)) u1 (.clk(clk), .rst_n(rst_n), .bc(bc), .rx(rx1), .ch_vld(vld1), .ch(ch1),
    .ch_rdy(rdy1), .term(term1), .frame_err(fe1), .parity_err(pe1), .ovf(ovf1), .level(lvl1));

  always #5 clk = ~clk;

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endfunction

  always @(negedge clk) if (rst_n) begin
    n_term[0] += int'(term0); n_fe[0] += int'(fe0); n_pe[0] += int'(pe0);
    n_term[1] += int'(term1); n_fe[1] += int'(fe1); n_pe[1] += int'(pe1);
    if (vld0 && rdy0) begin
      if (q0.size() == 0) begin checks++; errors++; $display("FAIL pop0 unexpected ch=%0h", ch0); end
      else chk("pop0", int'(ch0), q0.pop_front());
    end
    if (vld1 && rdy1) begin
      if (q1.size() == 0) begin checks++; errors++; $display("FAIL pop1 unexpected ch=%0h", ch1); end
      else chk("pop1", int'(ch1), q1.pop_front());
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic line(input int d, input logic b); if (d == 0) rx0 = b; else rx1 = b; endtask
  task automatic bit_out(input int d, input logic b); line(d, b); repeat (10) tick(); endtask
  task automatic send(input int d, input logic [7:0] v, input logic pb, input logic sb);
    bit_out(d, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(d, v[i]);
    if (d == 1) bit_out(d, pb);
    bit_out(d, sb);
  endtask
  task automatic chk_rst();
    chk("rst_vld0", int'(vld0), 0); chk("rst_ch0", int'(ch0), 0); chk("rst_term0", int'(term0), 0);
    chk("rst_fe0", int'(fe0), 0); chk("rst_pe0", int'(pe0), 0); chk("rst_ovf0", int'(ovf0), 0);
    chk("rst_lvl0", int'(lvl0), 0);
    chk("rst_vld1", int'(vld1), 0); chk("rst_ch1", int'(ch1), 0); chk("rst_term1", int'(term1), 0);
    chk("rst_fe1", int'(fe1), 0); chk("rst_pe1", int'(pe1), 0); chk("rst_ovf1", int'(ovf1), 0);
    chk("rst_lvl1", int'(lvl1), 0);
  endtask
  task automatic chk_cnt(string n, int d);
    chk({n, "_term"}, n_term[d], et[d]);
    chk({n, "_fe"}, n_fe[d], ef[d]);
    chk({n, "_pe"}, n_pe[d], ep[d]);
  endtask

  initial begin
    tv[0]  = '{0, 8'h41, 0, 1, 0,  1, 0, 0, 0};
    tv[1]  = '{0, 8'h42, 0, 1, 30, 1, 0, 0, 0};
    tv[2]  = '{0, 8'h10, 0, 1, 30, 0, 1, 0, 0};
    tv[3]  = '{0, 8'h55, 0, 0, 30, 0, 0, 1, 0};
    tv[4]  = '{0, 8'hA5, 0, 1, 30, 1, 0, 0, 0};
    tv[5]  = '{0, 8'h00, 0, 1, 30, 1, 0, 0, 0};
    tv[6]  = '{0, 8'hFF, 0, 1, 30, 1, 0, 0, 0};
    tv[7]  = '{1, 8'h03, 1, 1, 30, 0, 0, 0, 1};
    tv[8]  = '{1, 8'h03, 0, 1, 30, 1, 0, 0, 0};
    tv[9]  = '{1, 8'h10, 1, 1, 30, 0, 1, 0, 0};
    tv[10] = '{1, 8'h80, 1, 1, 30, 1, 0, 0, 0};
    tv[11] = '{1, 8'hC3, 1, 1, 30, 0, 0, 0, 1};
    tv[12] = '{1, 8'h5A, 1, 0, 30, 0, 0, 1, 0};
    rst_n = 1'b0;
    repeat (3) tick();
    chk_rst();
    rst_n = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 13; k++) begin
      if (tv[k].push) begin
        if (tv[k].d == 0) q0.push_back(int'(tv[k].v)); else q1.push_back(int'(tv[k].v));
      end
      et[tv[k].d] += int'(tv[k].trm);
      ef[tv[k].d] += int'(tv[k].fe);
      ep[tv[k].d] += int'(tv[k].pe);
      send(tv[k].d, tv[k].v, tv[k].pb, tv[k].sb);
      line(tv[k].d, 1'b1);
      if (tv[k].gap > 0) begin
        repeat (tv[k].gap) tick();
        chk_cnt($sformatf("row%0d", k), tv[k].d);
        chk($sformatf("row%0d_level", k), tv[k].d == 0 ? int'(lvl0) : int'(lvl1), 0);
        chk($sformatf("row%0d_pending", k), tv[k].d == 0 ? q0.size() : q1.size(), 0);
      end
    end
    line(0, 1'b0); tick(); line(0, 1'b1);
    repeat (30) tick();
    chk_cnt("glitch", 0);
    chk("glitch_vld", int'(vld0), 0);
    q0.push_back('h5A);
    send(0, 8'h5A, 1'b0, 1'b1);
    repeat (30) tick();
    chk("after_glitch_pending", q0.size(), 0);
    chk_cnt("after_glitch", 0);
    chk("ovf_pre", int'(ovf0), 0);
    rdy0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q0.push_back('h30 + i);
      send(0, 8'(8'h30 + i), 1'b0, 1'b1);
      repeat (5) tick();
    end
    repeat (10) tick();
    chk("full_level", int'(lvl0), 4);
    chk("full_ovf", int'(ovf0), 1);
    chk("full_vld", int'(vld0), 1);
    chk("full_head", int'(ch0), 'h30);
    rdy0 = 1'b1;
    repeat (10) tick();
    chk("drain_level", int'(lvl0), 0);
    chk("drain_pending", q0.size(), 0);
    chk("drain_ovf_sticky", int'(ovf0), 1);
    chk("drain_vld", int'(vld0), 0);
    rdy0 = 1'b0;
    q0.push_back('h11); q0.push_back('h22);
    send(0, 8'h11, 1'b0, 1'b1); repeat (5) tick();
    send(0, 8'h22, 1'b0, 1'b1); repeat (10) tick();
    chk("queued_level", int'(lvl0), 2);
    line(0, 1'b0);
    repeat (40) tick();
    rst_n = 1'b0;
    #2;
    chk_rst();
    q0.delete();
    line(0, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk_cnt("post_rst", 0);
    chk("post_rst_level", int'(lvl0), 0);
    chk("post_rst_vld", int'(vld0), 0);
    chk("post_rst_ovf", int'(ovf0), 0);
    rdy0 = 1'b1;
    q0.push_back('h7E);
    send(0, 8'h7E, 1'b0, 1'b1);
    repeat (30) tick();
    chk("clean_pending", q0.size(), 0);
    chk("clean_level", int'(lvl0), 0);
    chk_cnt("clean", 0);
    chk("final_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
